// File: rtl/cpu_pkg.sv
// Shared CPU definitions: operand widths, write-back opcodes and source decode.
// Imported by write-back, decode, EX forwarding and hazard logic.
package cpu_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_REG_AW = 3;
  localparam int DEF_CNT_W  = 16;
  localparam int OPC_W      = 4;
  localparam int IMM_W      = 3;

  typedef logic [DEF_REG_AW-1:0] reg_addr_t;
  typedef logic [DEF_DATA_W-1:0] data_t;
  typedef logic [OPC_W-1:0]      opcode_t;

  localparam opcode_t OP_LOAD  = 4'd5;
  localparam opcode_t OP_LOADI = 4'd6;

  typedef enum logic [1:0] {
    WB_SRC_ALU,
    WB_SRC_MEM,
    WB_SRC_IMM
  } wb_src_t;

  // Any opcode that is not a load of some kind writes back the ALU result.
  function automatic wb_src_t wb_src_of(input opcode_t opcode);
    case (opcode)
      OP_LOAD:  return WB_SRC_MEM;
      OP_LOADI: return WB_SRC_IMM;
      default:  return WB_SRC_ALU;
    endcase
  endfunction

endpackage

// File: rtl/wb_select.sv
// Write-back source mux and commit qualification (purely combinational).
// A write to r0 is never valid, so it neither commits, counts nor bypasses.
module wb_select
  import cpu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic              write_en,
  input  logic [OPC_W-1:0]  opcode,
  input  logic [REG_AW-1:0] dest,
  input  logic [DATA_W-1:0] alu,
  input  logic [DATA_W-1:0] load_data,
  input  logic [IMM_W-1:0]  imm,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  wb_src_t src;

  always_comb begin
    src  = wb_src_of(opcode);
    data = alu;
    case (src)
      WB_SRC_MEM: data = load_data;
      WB_SRC_IMM: data = DATA_W'(imm);
      default:    data = alu;
    endcase
  end

  assign valid = write_en && (dest != '0);

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: commits the selected value into the register file, serves two
// bypassed decode read ports and counts committed writes (saturating).
module wb_regfile
  import cpu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_write_i,
  input  logic [OPC_W-1:0]  wb_opcode_i,
  input  logic [REG_AW-1:0] wb_regD_i,
  input  logic [DATA_W-1:0] wb_alu_i,
  input  logic [DATA_W-1:0] wb_q_i,
  input  logic [IMM_W-1:0]  wb_imm_i,
  input  logic [REG_AW-1:0] rd_addr1_i,
  input  logic [REG_AW-1:0] rd_addr2_i,
  output logic [DATA_W-1:0] rd_data1_o,
  output logic [DATA_W-1:0] rd_data2_o,
  output logic              wb_valid_o,
  output logic [REG_AW-1:0] wb_addr_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic [CNT_W-1:0]  wb_count_o
);

  localparam int NREGS = 2 ** REG_AW;

  logic              wb_valid;
  logic [DATA_W-1:0] wb_data;
  logic [DATA_W-1:0] regs_reg [NREGS];
  logic [CNT_W-1:0]  count_reg;
  logic [CNT_W-1:0]  count_next;
  logic [REG_AW-1:0] rd_addr  [2];

  wb_select #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_wb_select (
    .write_en  (wb_write_i),
    .opcode    (wb_opcode_i),
    .dest      (wb_regD_i),
    .alu       (wb_alu_i),
    .load_data (wb_q_i),
    .imm       (wb_imm_i),
    .valid     (wb_valid),
    .data      (wb_data)
  );

  // Entry 0 is cleared on reset and never written because wb_valid excludes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_reg[i] <= '0;
      end
    end else if (wb_valid) begin
      regs_reg[wb_regD_i] <= wb_data;
    end
  end

  assign rd_addr[0] = rd_addr1_i;
  assign rd_addr[1] = rd_addr2_i;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
      logic [DATA_W-1:0] data;
      always_comb begin
        if (rd_addr[gi] == '0) begin
          data = '0;
        end else if (wb_valid && (rd_addr[gi] == wb_regD_i)) begin
          data = wb_data;
        end else begin
          data = regs_reg[rd_addr[gi]];
        end
      end
    end
  endgenerate

  assign rd_data1_o = g_rd[0].data;
  assign rd_data2_o = g_rd[1].data;

  always_comb begin
    count_next = count_reg;
    if (wb_valid && (count_reg != '1)) begin
      count_next = count_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign wb_valid_o = wb_valid;
  assign wb_addr_o  = wb_regD_i;
  assign wb_data_o  = wb_data;
  assign wb_count_o = count_reg;

endmodule

// File: tb/tb_wb_regfile.sv
// Randomized self-checking bench for wb_regfile against an array-based reference
// model of the register file, bypass rule and saturating commit counter.
module tb_wb_regfile;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       wb_write_i;
  logic [3:0] wb_opcode_i;
  logic [2:0] wb_regD_i;
  logic [7:0] wb_alu_i;
  logic [7:0] wb_q_i;
  logic [2:0] wb_imm_i;
  logic [2:0] rd_addr1_i;
  logic [2:0] rd_addr2_i;
  logic [7:0] rd_data1_o;
  logic [7:0] rd_data2_o;
  logic       wb_valid_o;
  logic [2:0] wb_addr_o;
  logic [7:0] wb_data_o;
  logic [15:0] wb_count_o;

  int checks   = 0;
  int failures = 0;
  int model_regs [8];
  int model_count;

  wb_regfile dut (
    .clk         (clk),
    .rst         (rst),
    .wb_write_i  (wb_write_i),
    .wb_opcode_i (wb_opcode_i),
    .wb_regD_i   (wb_regD_i),
    .wb_alu_i    (wb_alu_i),
    .wb_q_i      (wb_q_i),
    .wb_imm_i    (wb_imm_i),
    .rd_addr1_i  (rd_addr1_i),
    .rd_addr2_i  (rd_addr2_i),
    .rd_data1_o  (rd_data1_o),
    .rd_data2_o  (rd_data2_o),
    .wb_valid_o  (wb_valid_o),
    .wb_addr_o   (wb_addr_o),
    .wb_data_o   (wb_data_o),
    .wb_count_o  (wb_count_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int ref_wb_data(input int op, input int alu, input int q, input int imm);
    if (op == 5) return q;
    if (op == 6) return imm;
    return alu;
  endfunction

  function automatic int ref_read(input int addr, input bit v, input int rd, input int d);
    if (addr == 0) return 0;
    if (v && addr == rd) return d;
    return model_regs[addr];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) model_regs[i] = 0;
    model_count = 0;
  endtask

  task automatic model_commit(input bit v, input int rd, input int d);
    if (v) begin
      model_regs[rd] = d;
      if (model_count < 65535) model_count++;
    end
  endtask

  // One transaction: drive after an edge, check at the falling edge, commit at the next edge.
  task automatic step(input string tag, input bit w, input int op, input int rd, input int alu,
                      input int q, input int imm, input int a1, input int a2);
    bit v;
    int d;
    wb_write_i  = w;
    wb_opcode_i = op[3:0];
    wb_regD_i   = rd[2:0];
    wb_alu_i    = alu[7:0];
    wb_q_i      = q[7:0];
    wb_imm_i    = imm[2:0];
    rd_addr1_i  = a1[2:0];
    rd_addr2_i  = a2[2:0];
    @(negedge clk);
    v = w && (rd != 0);
    d = ref_wb_data(op, alu & 8'hFF, q & 8'hFF, imm & 7);
    check_eq({tag, ".rd1"},   32'(rd_data1_o), 32'(ref_read(a1, v, rd, d)));
    check_eq({tag, ".rd2"},   32'(rd_data2_o), 32'(ref_read(a2, v, rd, d)));
    check_eq({tag, ".valid"}, 32'(wb_valid_o), 32'(v));
    check_eq({tag, ".addr"},  32'(wb_addr_o),  32'(rd));
    check_eq({tag, ".data"},  32'(wb_data_o),  32'(d));
    check_eq({tag, ".count"}, 32'(wb_count_o), 32'(model_count));
    $display("TXN %s w=%0b op=%0d rd=%0d data=%02h rd1[%0d]=%02h rd2[%0d]=%02h cnt=%0d",
             tag, w, op, rd, wb_data_o, a1, rd_data1_o, a2, rd_data2_o, wb_count_o);
    @(posedge clk);
    model_commit(v, rd, d);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    wb_write_i = 1'b0; wb_opcode_i = '0; wb_regD_i = '0; wb_alu_i = '0;
    wb_q_i = '0; wb_imm_i = '0; rd_addr1_i = '0; rd_addr2_i = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset.count", 32'(wb_count_o), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) step("reset_read", 0, 0, 0, 0, 0, 0, i, 7 - i);

    step("bypass", 1, 1, 3, 8'hA5, 0, 0, 3, 0);
    step("stored", 0, 0, 0, 0, 0, 0, 3, 3);
    check_eq("stored.a5", 32'(rd_data1_o), 32'h0A5);

    step("load",  1, 5, 2, 8'hFF, 8'h3C, 0, 2, 3);
    step("loadi", 1, 6, 4, 8'h55, 8'h99, 6, 4, 2);
    step("ld_chk", 0, 0, 0, 0, 0, 0, 2, 4);

    step("r0_write", 1, 1, 0, 8'h77, 0, 0, 0, 0);
    step("r0_after", 0, 0, 0, 0, 0, 0, 0, 3);

    // Undefined opcode with write disabled must leave every register untouched.
    wb_write_i  = 1'b0;
    wb_opcode_i = 'x;
    @(negedge clk);
    check_eq("xop.valid", 32'(wb_valid_o), 32'd0);
    @(posedge clk);
    #1;
    step("xop_rd_a", 0, 0, 0, 0, 0, 0, 2, 3);
    step("xop_rd_b", 0, 0, 0, 0, 0, 0, 4, 1);

    for (int n = 0; n < 300; n++) begin
      int rd, a1, a2;
      rd = $urandom_range(0, 7);
      a1 = ($urandom_range(0, 2) == 0) ? rd : $urandom_range(0, 7);
      a2 = ($urandom_range(0, 2) == 0) ? rd : $urandom_range(0, 7);
      step("rand", 1'($urandom_range(0, 1)), $urandom_range(0, 15), rd,
           $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 7), a1, a2);
    end

    // Bring the counter up to 16'hFFFE with plain committed writes.
    while (model_count < 65534) begin
      int rd;
      rd = 1 + (model_count % 7);
      wb_write_i  = 1'b1;
      wb_opcode_i = 4'd1;
      wb_regD_i   = rd[2:0];
      wb_alu_i    = 8'(model_count);
      @(posedge clk);
      model_commit(1'b1, rd, model_count & 8'hFF);
      #1;
    end
    step("sat_w1", 1, 1, 1, 8'h21, 0, 0, 1, 2);
    step("sat_w2", 1, 1, 2, 8'h22, 0, 0, 1, 2);
    step("sat_w3", 1, 1, 3, 8'h23, 0, 0, 3, 2);
    step("sat_hold", 0, 0, 0, 0, 0, 0, 1, 3);
    check_eq("sat.ffff", 32'(wb_count_o), 32'hFFFF);

    // Reset asserted mid-cycle while a commit to r5 is pending.
    wb_write_i = 1'b1; wb_opcode_i = 4'd1; wb_regD_i = 3'd5; wb_alu_i = 8'h11;
    rd_addr1_i = 3'd5; rd_addr2_i = 3'd3;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("rst_mid.count", 32'(wb_count_o), 32'd0);
    check_eq("rst_mid.r3",    32'(rd_data2_o), 32'd0);
    @(posedge clk);
    #2;
    wb_write_i = 1'b0;
    rst = 1'b0;
    model_reset();
    step("post_rst", 0, 0, 0, 0, 0, 0, 5, 3);
    step("post_rst_w", 1, 1, 6, 8'h42, 0, 0, 6, 5);
    step("post_rst_r", 0, 0, 0, 0, 0, 0, 6, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back end of the MEM/WB pipeline register.
- Consumes the registered MEM/WB outputs: write enable, opcode, destination register, ALU result, load data and immediate.
- Selects the write-back value and commits it into the 8-entry x 8-bit architectural register file.
- Serves the two decode-stage read ports with same-cycle write-through bypass, and exports the write-back value for EX forwarding.

Parameters:
- DATA_W, 8, register/data width.
- REG_AW, 3, register address width (2**REG_AW entries).
- CNT_W, 16, width of committed-write counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- wb_write_i  input  1  write-enable from the MEM/WB stage (writeReg).
- wb_opcode_i  input  4  opcode from the MEM/WB stage.
- wb_regD_i  input  REG_AW  destination register.
- wb_alu_i  input  DATA_W  ALU result (alu_reg).
- wb_q_i  input  DATA_W  memory load data (q).
- wb_imm_i  input  3  immediate field.
- rd_addr1_i  input  REG_AW  decode read address 1.
- rd_addr2_i  input  REG_AW  decode read address 2.
- rd_data1_o  output  DATA_W  read data 1.
- rd_data2_o  output  DATA_W  read data 2.
- wb_valid_o  output  1  write-back commits this cycle (forwarding qualifier).
- wb_addr_o  output  REG_AW  write-back destination (forwarding).
- wb_data_o  output  DATA_W  selected write-back value (forwarding).
- wb_count_o  output  CNT_W  committed-write counter.

Behaviour:
- Reset (rst=1, async):
  - All registers clear to 8'h00.
  - wb_count_o clears to 0.
  - Combinational outputs follow the inputs; there are no registered outputs besides the counter.
- Write-back source select (combinational):
  - opcode==OP_LOAD: wb_data = wb_q_i.
  - opcode==OP_LOADI: wb_data = zero-extended wb_imm_i.
  - Otherwise: wb_data = wb_alu_i.
- Commit rule: wb_valid_o = wb_write_i && (wb_regD_i != 0).
- r0:
  - Hardwired zero; reads always return 8'h00.
  - A write to r0 is discarded, does not count, and does not bypass.
- Register write: on the rising clk edge with wb_valid_o=1, regs[wb_regD_i] <= wb_data. The value is visible to a plain read on the next cycle.
- Read ports:
  - Combinational.
  - Bypass priority: addr==0 -> 0; else (wb_valid_o && addr==wb_regD_i) -> wb_data; else regs[addr].
  - Each port bypasses independently; both ports may hit the same address.
- wb_addr_o and wb_data_o are driven every cycle regardless of valid; consumers must qualify them with wb_valid_o.
- Counter:
  - Increments by 1 on each committed write.
  - Saturates at all-ones (no wrap).
- Reset mid-operation:
  - Asserting rst in the same cycle as a commit discards the write; registers clear to 0.
  - On deassertion, the first capturing edge is the next rising clk edge.
- X-safety: an undefined opcode with wb_write_i=0 must not alter any state.

Decomposition:
- Package cpu_pkg:
  - OP_LOAD = 4'd5, OP_LOADI = 4'd6.
  - DATA_W and REG_AW defaults.
  - typedef reg_addr_t (logic [2:0]) and data_t (logic [7:0]).
  - Shared with the decode, EX forwarding and hazard logic.
- One sub-module: wb_select (pure combinational source mux plus valid qualification).
- Register array, bypass and counter stay in wb_regfile.

Test Plan:
- Reset, then read all 8 addresses on both ports -> every rd_data = 8'h00, wb_count_o = 0.
- wb_write=1, opcode=4'd1, regD=3, alu=8'hA5; rd_addr1=3 in the same cycle -> rd_data1=8'hA5 (bypass), wb_valid_o=1. Next cycle with write=0 -> rd_data1=8'hA5 (stored), count=1.
- opcode=OP_LOAD, regD=2, q=8'h3C, alu=8'hFF -> reg2=8'h3C. Then opcode=OP_LOADI, regD=4, imm=3'd6 -> reg4=8'h06.
- wb_write=1, regD=0, alu=8'h77 with rd_addr1=rd_addr2=0 -> both reads 8'h00, wb_valid_o=0, count unchanged.
- Preload counter to 16'hFFFE via 2 fewer writes (or force), then issue 3 valid writes -> count reaches 16'hFFFF and holds.
- Write regD=5, alu=8'h11 and assert rst asynchronously mid-cycle before the edge -> reg5 reads 8'h00 after release, count=0.
